// File: rtl/main_memory_if.sv
// Multi-cycle main-memory model behind the data-cache controller: 4-word refill
// bursts for read misses and single-word write-through stores.
module main_memory_if #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 4,
    parameter int LATENCY     = 4
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic [1:0]        rdata_offset,
    output logic              ready,
    output logic              busy
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

    state_t                 state_reg, state_next;
    logic [3:0]             cnt_reg, cnt_next;
    logic                   armed_reg, armed_next;
    logic [ADDR_W-OFF_W-1:0] base_reg, base_next;
    logic [OFF_W-1:0]       beat_reg, beat_next;
    logic [ADDR_W-1:0]      waddr_reg, waddr_next;
    logic [DATA_W-1:0]      wdata_reg, wdata_next;
    logic                   ready_reg, ready_next;
    logic                   valid_reg, valid_next;
    logic                   busy_reg, busy_next;
    logic [DATA_W-1:0]      rdata_reg;
    logic [1:0]             offset_reg;
    logic                   mem_we;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        armed_next = armed_reg;
        base_next  = base_reg;
        beat_next  = beat_reg;
        waddr_next = waddr_reg;
        wdata_next = wdata_reg;
        ready_next = 1'b0;
        valid_next = 1'b0;
        mem_we     = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // A request only fires after both enables were seen low in IDLE.
                if (!rd_en && !wr_en) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    armed_next = 1'b0;
                    cnt_next   = LAT_M1;
                    if (rd_en) begin
                        base_next  = addr[ADDR_W-1:OFF_W];
                        beat_next  = '0;
                        state_next = (LATENCY == 1) ? RD_BURST : RD_WAIT;
                    end else begin
                        waddr_next = addr;
                        wdata_next = wdata;
                        state_next = WR_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                // Leave one edge early so beat 0 lands exactly LATENCY edges after acceptance.
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RD_BURST;
                end
            end
            RD_BURST: begin
                valid_next = 1'b1;
                beat_next  = beat_reg + 1'b1;
                if (beat_reg == LAST_BEAT) begin
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            WR_WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd0) begin
                    mem_we     = 1'b1;
                    ready_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            armed_reg  <= 1'b0;
            base_reg   <= '0;
            beat_reg   <= '0;
            waddr_reg  <= '0;
            wdata_reg  <= '0;
            ready_reg  <= 1'b0;
            valid_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            rdata_reg  <= '0;
            offset_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            armed_reg <= armed_next;
            base_reg  <= base_next;
            beat_reg  <= beat_next;
            waddr_reg <= waddr_next;
            wdata_reg <= wdata_next;
            ready_reg <= ready_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            // Base and beat concatenate without carry, so the top block wraps naturally.
            if (state_reg == RD_BURST) begin
                rdata_reg  <= mem[{base_reg, beat_reg}];
                offset_reg <= 2'(beat_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr_reg] <= wdata_reg;
        end
    end

    assign rdata        = rdata_reg;
    assign rdata_valid  = valid_reg;
    assign rdata_offset = offset_reg;
    assign ready        = ready_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_main_memory_if.sv
// Bench for main_memory_if: a LATENCY=4 and a LATENCY=1 instance checked every cycle
// against a cycle-timeline model, plus literal checks on captured refill beats.
module tb_main_memory_if;

    localparam int MAXC = 2048;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_v [2];
    logic        wr_v [2];
    logic [9:0]  addr_v [2];
    logic [31:0] wdata_v [2];
    logic [31:0] rdata_v [2];
    logic        valid_v [2];
    logic [1:0]  off_v [2];
    logic        ready_v [2];
    logic        busy_v [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    main_memory_if #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4), .LATENCY(4)) u_dut4 (
        .clk(clk), .RST(rst_n), .rd_en(rd_v[0]), .wr_en(wr_v[0]), .addr(addr_v[0]),
        .wdata(wdata_v[0]), .rdata(rdata_v[0]), .rdata_valid(valid_v[0]),
        .rdata_offset(off_v[0]), .ready(ready_v[0]), .busy(busy_v[0]));

    main_memory_if #(.ADDR_W(10), .DATA_W(32), .BLOCK_WORDS(4), .LATENCY(1)) u_dut1 (
        .clk(clk), .RST(rst_n), .rd_en(rd_v[1]), .wr_en(wr_v[1]), .addr(addr_v[1]),
        .wdata(wdata_v[1]), .rdata(rdata_v[1]), .rdata_valid(valid_v[1]),
        .rdata_offset(off_v[1]), .ready(ready_v[1]), .busy(busy_v[1]));

    // Model: on acceptance, expected outputs are written into future cycle slots.
    int          cyc = 0;
    logic [31:0] mem_m [2][1024];
    bit          armed_m [2];
    int          done_m [2] = '{-1, -1};
    int          acc_m [2] = '{-1, -1};
    bit          s_valid [2][MAXC];
    bit          s_ready [2][MAXC];
    bit          s_we [2][MAXC];
    logic [31:0] s_data [2][MAXC];
    logic [1:0]  s_off [2][MAXC];
    logic [9:0]  s_waddr [2][MAXC];
    logic [31:0] s_wdat [2][MAXC];
    bit          e_valid [2], e_ready [2], e_busy [2];
    logic [31:0] e_data [2];
    logic [1:0]  e_off [2];
    logic [31:0] beats_q [2][$];

    always @(posedge clk) begin
        int lat;
        logic [9:0] idx;
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 4 : 1;
            if (!rst_n) begin
                armed_m[d] = 1'b0;
                done_m[d]  = -1;
                acc_m[d]   = -1;
                for (int k = cyc; k < MAXC; k++) begin
                    s_valid[d][k] = 1'b0;
                    s_ready[d][k] = 1'b0;
                    s_we[d][k]    = 1'b0;
                end
                e_valid[d] = 1'b0;
                e_ready[d] = 1'b0;
                e_busy[d]  = 1'b0;
                e_data[d]  = '0;
                e_off[d]   = '0;
            end else begin
                if (cyc > done_m[d]) begin
                    if (!rd_v[d] && !wr_v[d]) begin
                        armed_m[d] = 1'b1;
                    end else if (armed_m[d]) begin
                        armed_m[d] = 1'b0;
                        acc_m[d]   = cyc;
                        if (rd_v[d]) begin
                            for (int b = 0; b < 4; b++) begin
                                idx = {addr_v[d][9:2], 2'(b)};
                                s_valid[d][cyc+lat+b] = 1'b1;
                                s_off[d][cyc+lat+b]   = 2'(b);
                                s_data[d][cyc+lat+b]  = mem_m[d][idx];
                            end
                            s_ready[d][cyc+lat+3] = 1'b1;
                            done_m[d] = cyc + lat + 3;
                        end else begin
                            s_we[d][cyc+lat]    = 1'b1;
                            s_waddr[d][cyc+lat] = addr_v[d];
                            s_wdat[d][cyc+lat]  = wdata_v[d];
                            s_ready[d][cyc+lat] = 1'b1;
                            done_m[d] = cyc + lat;
                        end
                    end
                end
                if (s_we[d][cyc]) mem_m[d][s_waddr[d][cyc]] = s_wdat[d][cyc];
                e_valid[d] = s_valid[d][cyc];
                e_ready[d] = s_ready[d][cyc];
                if (s_valid[d][cyc]) begin
                    e_data[d] = s_data[d][cyc];
                    e_off[d]  = s_off[d][cyc];
                end
                e_busy[d] = (acc_m[d] >= 0) && (cyc >= acc_m[d]) && (cyc < done_m[d]);
            end
        end
        cyc++;
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rdata_valid", d, 32'(valid_v[d]), 32'(e_valid[d]));
            chk("ready", d, 32'(ready_v[d]), 32'(e_ready[d]));
            chk("busy", d, 32'(busy_v[d]), 32'(e_busy[d]));
            chk("rdata_offset", d, 32'(off_v[d]), 32'(e_off[d]));
            chk("rdata", d, rdata_v[d], e_data[d]);
            if (valid_v[d]) beats_q[d].push_back(rdata_v[d]);
        end
    end

    task automatic txn(input int d, input bit rd, input bit wr, input logic [9:0] a,
                       input logic [31:0] wd, input int hold);
        bit got;
        @(negedge clk);
        rd_v[d] = 1'b0;
        wr_v[d] = 1'b0;
        @(negedge clk);
        rd_v[d] = rd;
        wr_v[d] = wr;
        addr_v[d] = a;
        wdata_v[d] = wd;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = ready_v[d];
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout dut%0d addr %h: got no ready expected ready within 40 cycles", d, a);
        end
        repeat (hold) @(negedge clk);
        rd_v[d] = 1'b0;
        wr_v[d] = 1'b0;
        $display("txn dut%0d rd=%0d wr=%0d addr=%h wdata=%h", d, rd, wr, a, wd);
    endtask

    task automatic lit(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        chk(name, d, act, exp);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd_v[d] = 1'b0; wr_v[d] = 1'b0; addr_v[d] = '0; wdata_v[d] = '0;
        end
        // Reset with a read request held high.
        rd_v[0] = 1'b1;
        addr_v[0] = 10'h040;
        repeat (3) @(negedge clk);
        lit("reset_busy", 0, 32'(busy_v[0]), 32'd0);
        lit("reset_valid", 0, 32'(valid_v[0]), 32'd0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        lit("held_req_no_access_busy", 0, 32'(busy_v[0]), 32'd0);
        lit("held_req_no_beats", 0, 32'(beats_q[0].size()), 32'd0);
        rd_v[0] = 1'b0;

        // Preload and refill block 0x040 via an unaligned address.
        for (int i = 0; i < 4; i++) txn(0, 1'b0, 1'b1, 10'(10'h040 + i), 32'h000000A0 + 32'(i), 0);
        beats_q[0].delete();
        txn(0, 1'b1, 1'b0, 10'h042, 32'h0, 8);
        lit("refill_count", 0, 32'(beats_q[0].size()), 32'd4);
        lit("refill_beat0", 0, beats_q[0][0], 32'h000000A0);
        lit("refill_beat3", 0, beats_q[0][3], 32'h000000A3);

        // Write-through then read back its block.
        txn(0, 1'b0, 1'b1, 10'h014, 32'h14141414, 0);
        txn(0, 1'b0, 1'b1, 10'h016, 32'h16161616, 0);
        txn(0, 1'b0, 1'b1, 10'h017, 32'h17171717, 0);
        txn(0, 1'b0, 1'b1, 10'h015, 32'hDEADBEEF, 0);
        beats_q[0].delete();
        txn(0, 1'b1, 1'b0, 10'h014, 32'h0, 0);
        lit("write_readback_off1", 0, beats_q[0][1], 32'hDEADBEEF);
        lit("write_readback_off0", 0, beats_q[0][0], 32'h14141414);

        // Simultaneous read and write: read wins, memory untouched.
        for (int i = 0; i < 4; i++) txn(0, 1'b0, 1'b1, 10'(10'h100 + i), 32'h10000000 + 32'(i), 0);
        beats_q[0].delete();
        txn(0, 1'b1, 1'b1, 10'h100, 32'hBADBAD00, 0);
        lit("both_is_read", 0, 32'(beats_q[0].size()), 32'd4);
        beats_q[0].delete();
        txn(0, 1'b1, 1'b0, 10'h100, 32'h0, 0);
        lit("both_mem_unchanged", 0, beats_q[0][0], 32'h10000000);

        // Reset two edges into a write aborts the commit.
        for (int i = 0; i < 4; i++) txn(0, 1'b0, 1'b1, 10'(10'h200 + i), 32'h20000000 + 32'(i), 0);
        @(negedge clk);
        wr_v[0] = 1'b0;
        @(negedge clk);
        wr_v[0] = 1'b1; addr_v[0] = 10'h200; wdata_v[0] = 32'h12345678;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_v[0] = 1'b0;
        rst_n = 1'b1;
        $display("txn dut0 write addr=200 aborted by reset");
        beats_q[0].delete();
        txn(0, 1'b1, 1'b0, 10'h200, 32'h0, 0);
        lit("abort_mem_kept", 0, beats_q[0][0], 32'h20000000);

        // LATENCY=1 top block with wrap, then back-to-back read/write/read.
        for (int i = 0; i < 4; i++) txn(1, 1'b0, 1'b1, 10'(10'h3FC + i), 32'hF00D0000 + 32'(i), 0);
        beats_q[1].delete();
        txn(1, 1'b1, 1'b0, 10'h3FF, 32'h0, 0);
        lit("top_beat0", 1, beats_q[1][0], 32'hF00D0000);
        lit("top_beat3", 1, beats_q[1][3], 32'hF00D0003);
        txn(1, 1'b1, 1'b0, 10'h3FC, 32'h0, 0);
        txn(1, 1'b0, 1'b1, 10'h3FD, 32'h55AA55AA, 0);
        beats_q[1].delete();
        txn(1, 1'b1, 1'b0, 10'h3FC, 32'h0, 0);
        lit("b2b_write_seen", 1, beats_q[1][1], 32'h55AA55AA);
        lit("b2b_count", 1, 32'(beats_q[1].size()), 32'd4);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/main_memory_if.md
Name: main_memory_if

Overview:
- Multi-cycle main-memory model and interface that sits directly downstream of the data-cache controller.
- Consumes the controller's level-held rd_en/wr_en requests and returns a one-cycle ready pulse.
- Serves a read miss as a 4-word block refill burst, presented one word per cycle with its offset, for writing into the cache data array.
- Serves a write (write-through) as a single-word store.
- Memory array is internal and word-addressed.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data word width.
- BLOCK_WORDS, 4, words per cache block. Fixed at 4; offset is 2 bits.
- LATENCY, 4, access latency in cycles from request acceptance to first beat or write commit. Legal range 1..15.

Ports:
- clk, input, 1, clock. All logic is on the rising edge.
- RST, input, 1, asynchronous active-low reset.
- rd_en, input, 1, block-read (refill) request, held high until ready is seen.
- wr_en, input, 1, single-word write request, held high until ready is seen.
- addr, input, ADDR_W, word address. Read uses addr[ADDR_W-1:2] as block base.
- wdata, input, DATA_W, write data.
- rdata, output, DATA_W, refill beat data.
- rdata_valid, output, 1, refill beat valid.
- rdata_offset, output, 2, word offset of the current beat.
- ready, output, 1, one-cycle completion pulse.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (RST=0, async): state=IDLE, counter=0, armed=0. Outputs: ready=0, rdata_valid=0, rdata=0, rdata_offset=0, busy=0. Memory array contents are not reset. Reset mid-operation aborts the access: no write commit if the commit edge has not yet occurred, and no further beats.
- All outputs are registered.
- States: IDLE, RD_WAIT, RD_BURST, WR_WAIT.
- armed flag: set on any edge in IDLE where rd_en=0 and wr_en=0. Cleared on request acceptance. A request held high across completion or reset therefore never re-fires; requests must drop for at least one cycle first.
- IDLE, armed=1, edge E0:
  - rd_en=1 → latch block base = addr[ADDR_W-1:2], counter=LATENCY-1, go to RD_WAIT.
  - else wr_en=1 → latch addr and wdata, counter=LATENCY-1, go to WR_WAIT.
  - rd_en and wr_en both high → read wins; write is ignored.
- rd_en, wr_en, addr and wdata are ignored outside IDLE. Inputs are captured only at acceptance.
- RD_WAIT: decrement counter each edge. At the edge with counter=0, go to RD_BURST with beat=0. If LATENCY=1, E0 goes directly to RD_BURST.
- RD_BURST: at edges E0+LATENCY+b for b=0..3:
  - rdata=mem[{base,b}], rdata_valid=1, rdata_offset=b.
  - ready=1 only alongside beat 3.
  - After beat 3, go to IDLE; rdata_valid and ready fall at the next edge.
  - Beats are strictly in order 0,1,2,3, one per cycle, with no gaps.
- WR_WAIT: decrement counter. At edge E0+LATENCY, mem[addr]=wdata and ready=1 for exactly one cycle; go to IDLE.
- Total latency:
  - Read: first beat visible after E0+LATENCY; ready visible after E0+LATENCY+3.
  - Write: ready visible after E0+LATENCY.
- Address arithmetic: block base is concatenated with beat; no carry. Wrap is inherent at the top of the ADDR_W space.
- rdata holds its last value when rdata_valid=0. Consumers must qualify it with rdata_valid.
- busy rises the cycle after acceptance and falls the cycle after ready.

Test Plan:
- Reset: RST low with rd_en=1 → all outputs 0, busy=0. After RST rises with rd_en still 1, there is no access until rd_en drops for one cycle.
- Read refill, LATENCY=4: preload mem[0x40..0x43]=A0,A1,A2,A3; rd_en=1, addr=0x042 accepted at E0 → beats A0..A3 with offsets 0..3 after E4..E7. ready=1 only with A3. No second access while rd_en stays high.
- Write: wr_en=1, addr=0x015, wdata=0xDEADBEEF accepted at E0 → ready after E4 for one cycle. A subsequent read of block 0x014 returns 0xDEADBEEF at offset 1.
- Simultaneous rd_en=wr_en=1 at addr=0x100 → read burst only; mem[0x100] is unchanged.
- Reset at E2 of a write (wdata=0x12345678) → mem[addr] keeps its old value; ready is never asserted.
- LATENCY=1 and top block: rd_en, addr=0x3FF → beats from mem[0x3FC..0x3FF] start right after E1. Back-to-back read then write (each with a one-cycle deassert gap) both complete correctly.
